// File: rtl/vec_decode_q.sv
// rtl/vec_decode_q.sv - queued vector instruction decode stage
//
// Decodes vector instructions from the scalar issue point, captures their
// scalar operands and queues one decoded record per instruction in a
// DEPTH-entry FIFO that drains to the vector back end.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   vec_inst, rs1_data,
//   rs2_data, inst_valid       instruction + scalar operands from issue
//   inst_ready                 stage can take an instruction
//   is_vec                     vec_inst opcode is a vector opcode
//   flush                      synchronous queue clear
//   issue_valid / issue_ready  head record handshake
//   issue_*                    decoded head record fields (0 when empty)
//   count                      FIFO occupancy
module vec_decode_q #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] vec_inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            inst_valid,
  output logic            inst_ready,
  output logic            is_vec,
  input  logic            flush,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [1:0]      issue_class,
  output logic [2:0]      issue_func3,
  output logic [5:0]      issue_func6,
  output logic [4:0]      issue_vd,
  output logic [4:0]      issue_vs1,
  output logic [4:0]      issue_vs2,
  output logic            issue_vm,
  output logic [XLEN-1:0] issue_imm,
  output logic [2:0]      issue_width,
  output logic [2:0]      issue_nf,
  output logic            issue_mew,
  output logic [1:0]      issue_mop,
  output logic [XLEN-1:0] issue_scalar1,
  output logic [XLEN-1:0] issue_scalar2,
  output logic            issue_illegal,
  output logic [CW-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_CONF  = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  typedef struct packed {
    logic [1:0]      cls;
    logic [2:0]      func3;
    logic [5:0]      func6;
    logic [4:0]      vd;
    logic [4:0]      vs1;
    logic [4:0]      vs2;
    logic            vm;
    logic [XLEN-1:0] imm;
    logic [2:0]      width;
    logic [2:0]      nf;
    logic            mew;
    logic [1:0]      mop;
    logic [XLEN-1:0] scalar1;
    logic [XLEN-1:0] scalar2;
    logic            illegal;
  } rec_t;

  // Supported func6 encodings per operand category.
  function automatic logic f6_ivv(input logic [5:0] f);
    logic hit;
    case (f)
      6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11,
      6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27,
      6'd28, 6'd29, 6'd37, 6'd40, 6'd41: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic f6_ivi(input logic [5:0] f);
    logic hit;
    case (f)
      6'd0, 6'd3, 6'd9, 6'd10, 6'd11, 6'd16, 6'd17, 6'd24, 6'd25,
      6'd28, 6'd29, 6'd30, 6'd31, 6'd37, 6'd40, 6'd41: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic f6_mv(input logic [5:0] f);
    logic hit;
    case (f)
      6'd36, 6'd37, 6'd38, 6'd39, 6'd41, 6'd43, 6'd45, 6'd47: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  rec_t            rec_d;
  rec_t            head;
  rec_t            issue_rec;
  rec_t            mem_q [DEPTH];
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            legal;
  logic            full, empty, enq, deq;
  logic [CW-1:0]   count_d, count_q;
  logic [PW-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic            conf_pending_d, conf_pending_q;

  assign opcode = vec_inst[6:0];
  assign f3     = vec_inst[14:12];
  assign is_vec = (opcode == 7'h57) || (opcode == 7'h07) || (opcode == 7'h27);

  // Decode of the instruction currently presented at the input.
  always_comb begin
    rec_d       = '0;
    legal       = 1'b0;
    rec_d.func3 = f3;
    rec_d.func6 = vec_inst[31:26];
    rec_d.vd    = vec_inst[11:7];
    rec_d.vs1   = vec_inst[19:15];
    rec_d.vs2   = vec_inst[24:20];
    rec_d.vm    = vec_inst[25];
    if (opcode == 7'h07 || opcode == 7'h27) begin
      rec_d.cls     = (opcode == 7'h07) ? CLS_LOAD : CLS_STORE;
      rec_d.width   = f3;
      rec_d.nf      = vec_inst[31:29];
      rec_d.mew     = vec_inst[28];
      rec_d.mop     = vec_inst[27:26];
      rec_d.scalar1 = rs1_data;
      case (vec_inst[27:26])
        2'b00:   rec_d.scalar2 = XLEN'(vec_inst[24:20]);  // lumop/sumop
        2'b10:   rec_d.scalar2 = rs2_data;                // stride
        default: rec_d.scalar2 = '0;                      // indexed
      endcase
    end else if (f3 == 3'b111) begin
      rec_d.cls = CLS_CONF;
      rec_d.vs1 = '0;
      rec_d.vs2 = '0;
      if (!vec_inst[31]) begin                     // vsetvli
        rec_d.scalar1 = rs1_data;
        rec_d.scalar2 = XLEN'(vec_inst[30:20]);
      end else if (vec_inst[30]) begin             // vsetivli
        rec_d.scalar1 = XLEN'(vec_inst[19:15]);
        rec_d.scalar2 = XLEN'(vec_inst[29:20]);
      end else begin                               // vsetvl
        rec_d.scalar1 = rs1_data;
        rec_d.scalar2 = rs2_data;
      end
    end else begin
      rec_d.cls = CLS_ARITH;
      case (f3)
        3'b000:        legal = f6_ivv(vec_inst[31:26]);
        3'b011:        legal = f6_ivi(vec_inst[31:26]);
        3'b100:        legal = f6_ivv(vec_inst[31:26]) | f6_ivi(vec_inst[31:26]);
        3'b010, 3'b110: legal = f6_mv(vec_inst[31:26]);
        default:       legal = 1'b0;
      endcase
      rec_d.illegal = !legal;
      if (!legal) rec_d.func6 = '0;
      if (f3 == 3'b011) rec_d.imm = XLEN'($signed(vec_inst[19:15]));
      if (f3 == 3'b011 || f3 == 3'b100 || f3 == 3'b110) rec_d.vs1 = '0;
      if (f3 == 3'b100 || f3 == 3'b110) rec_d.scalar1 = rs1_data;
    end
  end

  // Queue control; flush wins over any simultaneous enqueue/dequeue.
  always_comb begin
    full           = (count_q == CW'(DEPTH));
    empty          = (count_q == '0);
    head           = mem_q[rd_ptr_q];
    inst_ready     = !full && !conf_pending_q;
    enq            = inst_valid && is_vec && inst_ready;
    deq            = !empty && issue_ready;
    count_d        = count_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    conf_pending_d = conf_pending_q;
    if (flush) begin
      count_d        = '0;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      conf_pending_d = 1'b0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq && !deq) count_d = count_q + CW'(1);
      else if (!enq && deq) count_d = count_q - CW'(1);
      // Only one conf can be in flight since it blocks further input.
      if (enq && rec_d.cls == CLS_CONF) conf_pending_d = 1'b1;
      else if (deq && head.cls == CLS_CONF) conf_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      conf_pending_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      conf_pending_q <= conf_pending_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem_q[wr_ptr_q] <= rec_d;
  end

  assign issue_valid   = !empty;
  assign issue_rec     = empty ? '0 : head;
  assign issue_class   = issue_rec.cls;
  assign issue_func3   = issue_rec.func3;
  assign issue_func6   = issue_rec.func6;
  assign issue_vd      = issue_rec.vd;
  assign issue_vs1     = issue_rec.vs1;
  assign issue_vs2     = issue_rec.vs2;
  assign issue_vm      = issue_rec.vm;
  assign issue_imm     = issue_rec.imm;
  assign issue_width   = issue_rec.width;
  assign issue_nf      = issue_rec.nf;
  assign issue_mew     = issue_rec.mew;
  assign issue_mop     = issue_rec.mop;
  assign issue_scalar1 = issue_rec.scalar1;
  assign issue_scalar2 = issue_rec.scalar2;
  assign issue_illegal = issue_rec.illegal;
  assign count         = count_q;

endmodule

// File: tb/tb_vec_decode_q.sv
// tb/tb_vec_decode_q.sv - scoreboard testbench for vec_decode_q
module tb_vec_decode_q;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam int IVV [22] = '{0, 2, 4, 5, 6, 7, 9, 10, 11, 16, 17, 18, 19, 24, 25, 26, 27, 28, 29, 37, 40, 41};
  localparam int IVI [16] = '{0, 3, 9, 10, 11, 16, 17, 24, 25, 28, 29, 30, 31, 37, 40, 41};
  localparam int MV  [8]  = '{36, 37, 38, 39, 41, 43, 45, 47};

  localparam logic [31:0] VADD    = 32'h020081D7;
  localparam logic [31:0] VADD2   = 32'h022081D7;
  localparam logic [31:0] VSETVLI = 32'h010372D7;
  localparam logic [31:0] BADOP   = 32'hBA0081D7;
  localparam logic [31:0] VLE32   = 32'h02056207;
  localparam logic [31:0] VLSE32  = 32'h0A056207;

  typedef struct packed {
    logic [1:0]  cls;
    logic [2:0]  func3;
    logic [5:0]  func6;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic        vm;
    logic [31:0] imm;
    logic [2:0]  width;
    logic [2:0]  nf;
    logic        mew;
    logic [1:0]  mop;
    logic [31:0] scalar1;
    logic [31:0] scalar2;
    logic        illegal;
  } rec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     vec_inst = '0, rs1_data = '0, rs2_data = '0;
  logic            inst_valid = 1'b0, flush = 1'b0, issue_ready = 1'b0;
  logic            inst_ready, is_vec, issue_valid, issue_vm, issue_mew, issue_illegal;
  logic [1:0]      issue_class, issue_mop;
  logic [2:0]      issue_func3, issue_width, issue_nf;
  logic [5:0]      issue_func6;
  logic [4:0]      issue_vd, issue_vs1, issue_vs2;
  logic [31:0]     issue_imm, issue_scalar1, issue_scalar2;
  logic [CW-1:0]   count;

  int n_err = 0;
  int n_chk = 0;
  rec_t mq[$];
  rec_t exp_q[$];
  bit   mconf = 1'b0;

  vec_decode_q #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .vec_inst(vec_inst), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .is_vec(is_vec), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_class(issue_class),
    .issue_func3(issue_func3), .issue_func6(issue_func6), .issue_vd(issue_vd),
    .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vm(issue_vm),
    .issue_imm(issue_imm), .issue_width(issue_width), .issue_nf(issue_nf),
    .issue_mew(issue_mew), .issue_mop(issue_mop),
    .issue_scalar1(issue_scalar1), .issue_scalar2(issue_scalar2),
    .issue_illegal(issue_illegal), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      if (n_err <= 50) $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic bit in_ivv(input int f);
    foreach (IVV[k]) if (IVV[k] == f) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit in_ivi(input int f);
    foreach (IVI[k]) if (IVI[k] == f) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit in_mv(input int f);
    foreach (MV[k]) if (MV[k] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_is_vec(input logic [31:0] i);
    int op;
    op = int'(i[6:0]);
    return (op == 'h57) || (op == 'h07) || (op == 'h27);
  endfunction

  // Reference decode written directly from the instruction-class rules.
  function automatic rec_t ref_decode(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    rec_t r;
    int op, f3, f6, s;
    bit ok;
    r  = '0;
    op = int'(i[6:0]);
    f3 = int'(i[14:12]);
    f6 = int'(i[31:26]);
    r.func3 = i[14:12];
    r.func6 = i[31:26];
    r.vd    = i[11:7];
    r.vs1   = i[19:15];
    r.vs2   = i[24:20];
    r.vm    = i[25];
    if (op == 'h07 || op == 'h27) begin
      r.cls     = (op == 'h07) ? 2'd2 : 2'd3;
      r.width   = i[14:12];
      r.nf      = i[31:29];
      r.mew     = i[28];
      r.mop     = i[27:26];
      r.scalar1 = r1;
      if (i[27:26] == 2'd0) r.scalar2 = 32'(i[24:20]);
      else if (i[27:26] == 2'd2) r.scalar2 = r2;
      else r.scalar2 = 32'd0;
    end else if (f3 == 7) begin
      r.cls = 2'd1;
      r.vs1 = 5'd0;
      r.vs2 = 5'd0;
      if (i[31] == 1'b0) begin
        r.scalar1 = r1;
        r.scalar2 = 32'(i[30:20]);
      end else if (i[30] == 1'b1) begin
        r.scalar1 = 32'(i[19:15]);
        r.scalar2 = 32'(i[29:20]);
      end else begin
        r.scalar1 = r1;
        r.scalar2 = r2;
      end
    end else begin
      ok = (f3 == 0 && in_ivv(f6)) || (f3 == 3 && in_ivi(f6)) ||
           (f3 == 4 && (in_ivv(f6) || in_ivi(f6))) ||
           ((f3 == 2 || f3 == 6) && in_mv(f6));
      r.illegal = !ok;
      if (!ok) r.func6 = 6'd0;
      if (f3 == 3) begin
        s = int'(i[19:15]);
        if (s >= 16) s = s - 32;
        r.imm = 32'(s);
      end
      if (f3 == 3 || f3 == 4 || f3 == 6) r.vs1 = 5'd0;
      if (f3 == 4 || f3 == 6) r.scalar1 = r1;
    end
    return r;
  endfunction

  // Reference queue: evolves on each clock edge from the driven inputs only.
  rec_t r_new;
  bit   m_rdy, m_deq, m_acc;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_q.delete();
      mconf = 1'b0;
    end else begin
      m_rdy = (mq.size() < DEPTH) && !mconf;
      m_deq = (mq.size() != 0) && issue_ready;
      m_acc = inst_valid && model_is_vec(vec_inst) && m_rdy;
      if (flush) begin
        mq.delete();
        exp_q.delete();
        mconf = 1'b0;
      end else begin
        if (m_deq) begin
          if (mq[0].cls == 2'd1) mconf = 1'b0;
          void'(mq.pop_front());
        end
        if (m_acc) begin
          r_new = ref_decode(vec_inst, rs1_data, rs2_data);
          mq.push_back(r_new);
          exp_q.push_back(r_new);
          if (r_new.cls == 2'd1) mconf = 1'b1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the scoreboard head mid-cycle.
  rec_t act, expr;
  always @(negedge clk) begin
    act.cls = issue_class;     act.func3 = issue_func3;   act.func6 = issue_func6;
    act.vd = issue_vd;         act.vs1 = issue_vs1;       act.vs2 = issue_vs2;
    act.vm = issue_vm;         act.imm = issue_imm;       act.width = issue_width;
    act.nf = issue_nf;         act.mew = issue_mew;       act.mop = issue_mop;
    act.scalar1 = issue_scalar1; act.scalar2 = issue_scalar2; act.illegal = issue_illegal;
    expr = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("count", 64'(count), 64'(mq.size()));
    chk("inst_ready", 64'(inst_ready), 64'((mq.size() < DEPTH) && !mconf));
    chk("is_vec", 64'(is_vec), 64'(model_is_vec(vec_inst)));
    chk("issue_valid", 64'(issue_valid), 64'(exp_q.size() != 0));
    n_chk++;
    if (act !== expr) begin
      n_err++;
      if (n_err <= 50) $display("FAIL record act=%h exp=%h", act, expr);
    end
    if (exp_q.size() != 0 && issue_ready && !reset) void'(exp_q.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    int k;
    x = $urandom();
    k = $urandom_range(0, 9);
    if (k <= 4) begin
      x[6:0]   = 7'h57;
      x[14:12] = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0: x[31:26] = 6'(IVV[$urandom_range(0, 21)]);
        1: x[31:26] = 6'(IVI[$urandom_range(0, 15)]);
        2: x[31:26] = 6'(MV[$urandom_range(0, 7)]);
        default: ;
      endcase
    end else if (k == 5) begin
      x[6:0]   = 7'h57;
      x[14:12] = 3'd7;
    end else if (k <= 7) begin
      x[6:0] = 7'h07;
    end else if (k == 8) begin
      x[6:0] = 7'h27;
    end else begin
      x[6:0] = 7'h33;
    end
    return x;
  endfunction

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    // Reset state
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_ready", 64'(inst_ready), 64'd1);

    // vadd.vv with issue_ready high: visible exactly one cycle after accept
    tick();
    vec_inst = VADD; rs1_data = 32'h11; rs2_data = 32'h22;
    inst_valid = 1'b1; issue_ready = 1'b1;
    @(negedge clk);
    chk("no_bypass", 64'(issue_valid), 64'd0);
    tick();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("vadd_valid", 64'(issue_valid), 64'd1);
    chk("vadd_class", 64'(issue_class), 64'd0);
    chk("vadd_vd", 64'(issue_vd), 64'd3);
    chk("vadd_vs1", 64'(issue_vs1), 64'd1);
    chk("vadd_vm", 64'(issue_vm), 64'd1);
    chk("vadd_illegal", 64'(issue_illegal), 64'd0);
    tick();
    @(negedge clk);
    chk("vadd_drained", 64'(count), 64'd0);

    // vsetvli serialises the following vadd
    vec_inst = VSETVLI; rs1_data = 32'h40; inst_valid = 1'b1; issue_ready = 1'b0;
    tick();
    vec_inst = VADD2; rs1_data = 32'h5;
    @(negedge clk);
    chk("conf_class", 64'(issue_class), 64'd1);
    chk("conf_s1", 64'(issue_scalar1), 64'h40);
    chk("conf_s2", 64'(issue_scalar2), 64'h10);
    chk("conf_block", 64'(inst_ready), 64'd0);
    tick();
    tick();
    issue_ready = 1'b1;
    @(negedge clk);
    chk("conf_block2", 64'(inst_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("conf_release", 64'(inst_ready), 64'd1);
    chk("conf_no_vadd_yet", 64'(count), 64'd0);
    tick();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("vadd2_vs2", 64'(issue_vs2), 64'd2);
    chk("vadd2_vd", 64'(issue_vd), 64'd3);
    tick();

    // Unsupported func6
    vec_inst = BADOP; inst_valid = 1'b1; issue_ready = 1'b0;
    tick();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("bad_illegal", 64'(issue_illegal), 64'd1);
    chk("bad_func6", 64'(issue_func6), 64'd0);
    issue_ready = 1'b1;
    tick();

    // Unit-stride and strided loads
    vec_inst = VLE32; rs1_data = 32'h1000; rs2_data = 32'h77;
    inst_valid = 1'b1; issue_ready = 1'b0;
    tick();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("vle_class", 64'(issue_class), 64'd2);
    chk("vle_width", 64'(issue_width), 64'd6);
    chk("vle_vd", 64'(issue_vd), 64'd4);
    chk("vle_s1", 64'(issue_scalar1), 64'h1000);
    chk("vle_s2", 64'(issue_scalar2), 64'd0);
    issue_ready = 1'b1;
    tick();
    vec_inst = VLSE32; rs2_data = 32'h20; inst_valid = 1'b1; issue_ready = 1'b0;
    tick();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("vlse_s2", 64'(issue_scalar2), 64'h20);
    chk("vlse_mop", 64'(issue_mop), 64'd2);
    issue_ready = 1'b1;
    tick();

    // Fill, drain with input held, then flush during enq/deq
    vec_inst = VADD; inst_valid = 1'b1; issue_ready = 1'b0;
    repeat (DEPTH + 2) tick();
    @(negedge clk);
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_ready", 64'(inst_ready), 64'd0);
    issue_ready = 1'b1;
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(issue_valid), 64'd0);

    // Non-vector instruction has no effect
    vec_inst = 32'h00000033; inst_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("nonvec_count", 64'(count), 64'd0);
    inst_valid = 1'b0;

    // Randomised traffic
    repeat (2000) begin
      tick();
      vec_inst    = rand_inst();
      rs1_data    = $urandom();
      rs2_data    = $urandom();
      inst_valid  = ($urandom_range(0, 9) < 6);
      issue_ready = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 39) == 0);
    end
    flush = 1'b0;

    // Asynchronous reset mid-operation
    vec_inst = VADD; inst_valid = 1'b1; issue_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(issue_valid), 64'd0);
    tick();
    reset = 1'b0; inst_valid = 1'b0; issue_ready = 1'b1;
    repeat (3) tick();

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
